// File: rtl/count16_seq_checker_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
// Shared types and constants for the count16 sequence checker.
//   state_t    : checker FSM states (IDLE / ACQ / TRACK)
//   COUNT_W    : default width of the observed counter
//   STAT_W     : default width of the statistics counters
//   next_count : value + 1 wrapped to 'width' bits
// ---------------------------------------------------------------------------
package count_seq_pkg;

  localparam int COUNT_W = 4;
  localparam int STAT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Successor of 'value' modulo 2^width. Carried at 32 bits so one function
  // serves any parameterised width; callers truncate to their own width.
  function automatic logic [31:0] next_count(input logic [31:0] value,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/count16_seq_checker_if.sv
// ---------------------------------------------------------------------------
// count16_seq_checker_if
// Sample bus and status bundle between a sample source and the checker.
//   in_valid / in_count / clear        : source -> checker
//   locked / wrap_pulse / err_pulse /
//   err_sticky / wrap_count /
//   err_count / last_count             : checker -> source
// Modports: master (source side), slave (checker side).
// ---------------------------------------------------------------------------
interface count16_seq_checker_if
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = COUNT_W,
  parameter int WRAP_W = STAT_W,
  parameter int ERR_W  = STAT_W
);

  logic              in_valid;
  logic [WIDTH-1:0]  in_count;
  logic              clear;
  logic              locked;
  logic              wrap_pulse;
  logic              err_pulse;
  logic              err_sticky;
  logic [WRAP_W-1:0] wrap_count;
  logic [ERR_W-1:0]  err_count;
  logic [WIDTH-1:0]  last_count;

  modport master (
    output in_valid, in_count, clear,
    input  locked, wrap_pulse, err_pulse, err_sticky,
           wrap_count, err_count, last_count
  );

  modport slave (
    input  in_valid, in_count, clear,
    output locked, wrap_pulse, err_pulse, err_sticky,
           wrap_count, err_count, last_count
  );

endinterface

// File: rtl/count16_seq_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk     : clock
//   reset   : synchronous, active-low reset
//   i_inc   : count one event
//   i_clr   : clear; clear together with inc yields 1 so the event survives
//   o_count : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= W'(i_inc);
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count16_seq_checker.sv
// ---------------------------------------------------------------------------
// count16_seq_checker
// Passive monitor for a free-running up-counter. Each valid sample is
// compared against the previous accepted sample plus one (mod 2^WIDTH).
//   clk   : clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : slave side of count16_seq_checker_if
//           in:  in_valid, in_count, clear
//           out: locked, wrap_pulse, err_pulse, err_sticky,
//                wrap_count, err_count, last_count
// ---------------------------------------------------------------------------
module count16_seq_checker
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = COUNT_W,
  parameter int LOCK_N = 2,
  parameter int WRAP_W = STAT_W,
  parameter int ERR_W  = STAT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  count16_seq_checker_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_CNT  = '1;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_N);

  state_t           r_state, w_state_next;
  logic [3:0]       r_match, w_match_next;
  logic [3:0]       w_match_inc;
  logic [WIDTH-1:0] r_prev, w_prev_next;
  logic [WIDTH-1:0] w_expected;
  logic             w_good;
  logic             w_wrap_evt, w_err_evt;
  logic             r_wrap_pulse, r_err_pulse, r_err_sticky;
  logic [WRAP_W-1:0] w_wrap_count;
  logic [ERR_W-1:0]  w_err_count;

  assign w_expected  = WIDTH'(next_count(32'(r_prev), WIDTH));
  assign w_good      = (bus.in_count == w_expected);
  assign w_match_inc = r_match + 4'd1;

  // State register plus the registered pulse/sticky outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_match      <= '0;
      r_prev       <= '0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_match      <= w_match_next;
      r_prev       <= w_prev_next;
      r_wrap_pulse <= w_wrap_evt;
      r_err_pulse  <= w_err_evt;
      // An error in the same cycle as clear wins so it is never lost.
      if (w_err_evt) begin
        r_err_sticky <= 1'b1;
      end else if (bus.clear) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  // Next-state logic. Without in_valid everything holds.
  always_comb begin
    w_state_next = r_state;
    w_match_next = r_match;
    if (bus.in_valid) begin
      case (r_state)
        IDLE: begin
          w_state_next = ACQ;
          w_match_next = '0;
        end
        ACQ: begin
          if (w_good) begin
            w_match_next = w_match_inc;
            if (w_match_inc == LOCK_TGT) begin
              w_state_next = TRACK;
            end
          end else begin
            w_match_next = '0;
          end
        end
        TRACK: begin
          if (!w_good) begin
            w_state_next = ACQ;
            w_match_next = '0;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_match_next = '0;
        end
      endcase
    end
  end

  // Output/event logic. Every accepted sample becomes the new reference,
  // good or bad, so prev simply follows in_count on valid cycles.
  always_comb begin
    w_prev_next = r_prev;
    w_wrap_evt  = 1'b0;
    w_err_evt   = 1'b0;
    if (bus.in_valid) begin
      w_prev_next = bus.in_count;
      if (r_state == TRACK) begin
        // A good sample following all-ones is necessarily the wrap to zero.
        w_wrap_evt = w_good && (r_prev == MAX_CNT);
        w_err_evt  = !w_good;
      end
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_wrap_evt),
    .i_clr  (bus.clear),
    .o_count(w_wrap_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_err_evt),
    .i_clr  (bus.clear),
    .o_count(w_err_count)
  );

  assign bus.locked     = (r_state == TRACK);
  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_sticky = r_err_sticky;
  assign bus.wrap_count = w_wrap_count;
  assign bus.err_count  = w_err_count;
  assign bus.last_count = r_prev;

endmodule

// File: tb/tb_count16_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_count16_seq_checker
// Drives two checkers (wrap counter 8 bits and 2 bits) with the same sample
// stream: directed scenarios followed by random traffic. Expected outputs
// come from a run-length reference model: a sample stream is locked once
// LOCK_N consecutive +1 steps have been seen since the last break.
// ---------------------------------------------------------------------------
module tb_count16_seq_checker;

  localparam int LOCK_N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  count16_seq_checker_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(8)) ifa ();
  count16_seq_checker_if #(.WIDTH(4), .WRAP_W(2), .ERR_W(8)) ifb ();

  count16_seq_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .WRAP_W(8), .ERR_W(8)) dut_a (
    .clk  (clk),
    .reset(rst_n),
    .bus  (ifa)
  );

  count16_seq_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .WRAP_W(2), .ERR_W(8)) dut_b (
    .clk  (clk),
    .reset(rst_n),
    .bus  (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_have = 0;
  int m_prev = 0;
  int m_run = 0;
  bit m_wp = 0, m_ep = 0, m_sticky = 0;
  int m_wca = 0, m_wcb = 0, m_ec = 0;

  int cur = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit v, input int c, input bit clr, input bit rn);
    bit wev, eev;
    wev = 0;
    eev = 0;
    if (!rn) begin
      m_have = 0; m_prev = 0; m_run = 0;
      m_wp = 0; m_ep = 0; m_sticky = 0;
      m_wca = 0; m_wcb = 0; m_ec = 0;
      return;
    end
    if (v) begin
      if (!m_have) begin
        m_have = 1;
        m_run  = 0;
      end else if (c == (m_prev + 1) % 16) begin
        if (m_run >= LOCK_N && c == 0) wev = 1;
        if (m_run < 1000) m_run++;
      end else begin
        if (m_run >= LOCK_N) eev = 1;
        m_run = 0;
      end
      m_prev = c;
    end
    if (clr) begin
      m_wca = wev ? 1 : 0;
      m_wcb = wev ? 1 : 0;
      m_ec  = eev ? 1 : 0;
    end else begin
      if (wev && m_wca < 255) m_wca++;
      if (wev && m_wcb < 3)   m_wcb++;
      if (eev && m_ec < 255)  m_ec++;
    end
    if (eev) m_sticky = 1;
    else if (clr) m_sticky = 0;
    m_wp = wev;
    m_ep = eev;
  endtask

  task automatic step(input bit v, input int c, input bit clr, input bit rn);
    bit m_locked;
    ifa.in_valid = v;  ifa.in_count = 4'(c);  ifa.clear = clr;
    ifb.in_valid = v;  ifb.in_count = 4'(c);  ifb.clear = clr;
    rst_n = rn;
    @(posedge clk);
    model_step(v, c, clr, rn);
    m_locked = m_have && (m_run >= LOCK_N);
    #1;
    check("locked_a",     32'(ifa.locked),     32'(m_locked));
    check("wrap_pulse_a", 32'(ifa.wrap_pulse), 32'(m_wp));
    check("err_pulse_a",  32'(ifa.err_pulse),  32'(m_ep));
    check("err_sticky_a", 32'(ifa.err_sticky), 32'(m_sticky));
    check("wrap_count_a", 32'(ifa.wrap_count), 32'(m_wca));
    check("err_count_a",  32'(ifa.err_count),  32'(m_ec));
    check("last_count_a", 32'(ifa.last_count), 32'(m_prev));
    check("locked_b",     32'(ifb.locked),     32'(m_locked));
    check("wrap_count_b", 32'(ifb.wrap_count), 32'(m_wcb));
    check("err_count_b",  32'(ifb.err_count),  32'(m_ec));
    check("pulse_excl_a", 32'(ifa.wrap_pulse & ifa.err_pulse), 32'd0);
    $display("[TB] t=%0t v=%0d c=%0d clr=%0d rst_n=%0d -> locked=%0d wp=%0d ep=%0d sticky=%0d wc=%0d/%0d ec=%0d last=%0d",
             $time, v, c, clr, rn, ifa.locked, ifa.wrap_pulse, ifa.err_pulse,
             ifa.err_sticky, ifa.wrap_count, ifb.wrap_count, ifa.err_count, ifa.last_count);
  endtask

  // Valid sample, no clear, reset released
  task automatic send(input int c);
    step(1, c, 0, 1);
    cur = c;
  endtask

  initial begin
    // 1: reset for two cycles, then 0,1,2 acquires lock
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    send(0);
    send(1);
    check("t1_not_locked_yet", 32'(ifa.locked), 32'd0);
    send(2);
    check("t1_locked", 32'(ifa.locked), 32'd1);

    // 2: two full laps, one wrap each
    for (int i = 3; i <= 15; i++) send(i);
    send(0);
    check("t2_wrap_pulse", 32'(ifa.wrap_pulse), 32'd1);
    send(1);
    check("t2_wrap_pulse_gone", 32'(ifa.wrap_pulse), 32'd0);
    for (int i = 2; i <= 15; i++) send(i);
    send(0);
    check("t2_wrap_count", 32'(ifa.wrap_count), 32'd2);

    // 3: error at 4 -> 7, then relock on 8,9
    for (int i = 1; i <= 4; i++) send(i);
    send(7);
    check("t3_err_pulse", 32'(ifa.err_pulse), 32'd1);
    check("t3_unlocked", 32'(ifa.locked), 32'd0);
    send(8);
    check("t3_err_pulse_gone", 32'(ifa.err_pulse), 32'd0);
    send(9);
    check("t3_relocked", 32'(ifa.locked), 32'd1);
    check("t3_err_count", 32'(ifa.err_count), 32'd1);

    // 4: gap of five invalid cycles at 3, then 4
    for (int i = 10; i <= 15; i++) send(i);
    for (int i = 0; i <= 3; i++) send(i);
    for (int i = 0; i < 5; i++) step(0, $urandom_range(15), 0, 1);
    send(4);
    check("t4_still_locked", 32'(ifa.locked), 32'd1);
    check("t4_no_err", 32'(ifa.err_count), 32'd1);

    // 5: clear together with an error, then clear alone
    step(1, 9, 1, 1);
    cur = 9;
    check("t5_err_with_clear", 32'(ifa.err_count), 32'd1);
    check("t5_sticky_with_clear", 32'(ifa.err_sticky), 32'd1);
    step(0, 0, 1, 1);
    check("t5_clear_count", 32'(ifa.err_count), 32'd0);
    check("t5_clear_sticky", 32'(ifa.err_sticky), 32'd0);
    send(10);
    send(11);

    // 6: five laps saturate the 2-bit wrap counter, then reset mid-TRACK
    for (int i = 0; i < 80; i++) send((cur + 1) % 16);
    check("t6_wrap_sat_b", 32'(ifb.wrap_count), 32'd3);
    check("t6_wrap_a", 32'(ifa.wrap_count), 32'd5);
    step(1, 5, 0, 0);
    check("t6_reset_locked", 32'(ifa.locked), 32'd0);
    check("t6_reset_last", 32'(ifa.last_count), 32'd0);
    send(9);
    check("t6_first_no_err", 32'(ifa.err_pulse), 32'd0);
    send(10);
    send(11);
    check("t6_relocked", 32'(ifa.locked), 32'd1);

    // Random traffic: mostly in-sequence, occasional jumps, gaps, clears, resets
    for (int i = 0; i < 300; i++) begin
      bit v, clr, rn;
      int c;
      v   = ($urandom_range(3) != 0);
      clr = ($urandom_range(15) == 0);
      rn  = ($urandom_range(63) != 0);
      c   = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : (cur + 1) % 16;
      step(v, c, clr, rn);
      if (v) cur = c;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
